// File: rtl/pulp_logic_pkg.sv
// Shared types for the pipelined bitwise logic unit.
package pulp_logic_pkg;

  typedef enum logic [3:0] {
    OpAnd  = 4'd0,
    OpOr   = 4'd1,
    OpXor  = 4'd2,
    OpAndn = 4'd3,
    OpOrn  = 4'd4,
    OpXnor = 4'd5,
    OpRand = 4'd6,
    OpRor  = 4'd7,
    OpRxor = 4'd8
  } logic_op_e;

  // Any opcode above this is illegal.
  localparam logic [3:0] LOGIC_OP_LAST = OpRxor;

endpackage

// File: rtl/pulp_logic_pipe_if.sv
// Upstream issue and downstream result handshakes of pulp_logic_pipe.
interface pulp_logic_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [3:0]       in_op_i;
  logic             in_acc_i;
  logic [WIDTH-1:0] in_a_i;
  logic [WIDTH-1:0] in_b_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_result_o;
  logic             out_err_o;

  modport master (
    output in_valid_i, in_op_i, in_acc_i, in_a_i, in_b_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_result_o, out_err_o
  );

  modport slave (
    input  in_valid_i, in_op_i, in_acc_i, in_a_i, in_b_i, out_ready_i,
    output in_ready_o, out_valid_o, out_result_o, out_err_o
  );
endinterface

// File: rtl/pulp_logic_lane.sv
// One SIMD lane: all bitwise ops plus the lane reduction, which lands in bit 0.
module pulp_logic_lane
  import pulp_logic_pkg::*;
#(
  parameter int unsigned LANE_W = 8
) (
  input  logic [3:0]        op_i,
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  output logic [LANE_W-1:0] res_o
);

  always_comb begin
    res_o = '0;
    case (logic_op_e'(op_i))
      OpAnd:   res_o = a_i & b_i;
      OpOr:    res_o = a_i | b_i;
      OpXor:   res_o = a_i ^ b_i;
      OpAndn:  res_o = a_i & ~b_i;
      OpOrn:   res_o = a_i | ~b_i;
      OpXnor:  res_o = ~(a_i ^ b_i);
      OpRand:  res_o[0] = &a_i;
      OpRor:   res_o[0] = |a_i;
      OpRxor:  res_o[0] = ^a_i;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/pulp_logic_pipe.sv
// Two-stage pipelined logic unit with valid/ready handshakes and an accumulator
// that feeds back as operand A without forwarding.
module pulp_logic_pipe
  import pulp_logic_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LANE_W = 8
) (
  input logic              clk,
  input logic              rst,
  pulp_logic_pipe_if.slave bus
);

  localparam int unsigned NumLanes = WIDTH / LANE_W;

  if ((WIDTH % LANE_W) != 0) begin : gen_width_check
    $error("WIDTH must be a multiple of LANE_W");
  end

  logic             s1_valid_q, s1_acc_q;
  logic [3:0]       s1_op_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic             s2_valid_q, s2_err_q;
  logic [WIDTH-1:0] s2_result_q, acc_q;

  logic             s1_move, s2_move, s1_load, s2_load, op_illegal;
  logic [WIDTH-1:0] eff_a, lane_res, s2_result_d;

  always_comb begin
    s2_move     = !s2_valid_q || bus.out_ready_i;
    s1_move     = !s1_valid_q || s2_move;
    s1_load     = bus.in_valid_i && s1_move;
    s2_load     = s1_valid_q && s2_move;
    op_illegal  = s1_op_q > LOGIC_OP_LAST;
    // The accumulator is read at the same edge it is written, so chained
    // acc ops see the previous result without a bubble.
    eff_a       = s1_acc_q ? acc_q : s1_a_q;
    s2_result_d = op_illegal ? '0 : lane_res;
  end

  for (genvar i = 0; i < NumLanes; i++) begin : gen_lane
    pulp_logic_lane #(
      .LANE_W(LANE_W)
    ) u_lane (
      .op_i (s1_op_q),
      .a_i  (eff_a[i*LANE_W +: LANE_W]),
      .b_i  (s1_b_q[i*LANE_W +: LANE_W]),
      .res_o(lane_res[i*LANE_W +: LANE_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_acc_q    <= 1'b0;
      s1_op_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_err_q    <= 1'b0;
      s2_result_q <= '0;
      acc_q       <= '0;
    end else begin
      if (s1_move) s1_valid_q <= bus.in_valid_i;
      if (s1_load) begin
        s1_op_q  <= bus.in_op_i;
        s1_acc_q <= bus.in_acc_i;
        s1_a_q   <= bus.in_a_i;
        s1_b_q   <= bus.in_b_i;
      end
      if (s2_move) s2_valid_q <= s1_valid_q;
      if (s2_load) begin
        s2_result_q <= s2_result_d;
        s2_err_q    <= op_illegal;
        if (!op_illegal) acc_q <= s2_result_d;
      end
    end
  end

  assign bus.in_ready_o   = s1_move;
  assign bus.out_valid_o  = s2_valid_q;
  assign bus.out_result_o = s2_result_q;
  assign bus.out_err_o    = s2_err_q;

endmodule

// File: tb/tb_pulp_logic_pipe.sv
// Directed bench for pulp_logic_pipe with hand-computed expected results.
module tb_pulp_logic_pipe;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned LANE_W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pulp_logic_pipe_if #(.WIDTH(WIDTH)) bus ();

  pulp_logic_pipe #(
    .WIDTH (WIDTH),
    .LANE_W(LANE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_basic [6] = '{32'h1, 32'h7, 32'h6, 32'h4, 32'hFFFF_FFFD, 32'hFFFF_FFF9};
  logic [3:0]  red_ops   [3] = '{4'd8, 4'd7, 4'd6};
  logic [31:0] exp_red   [3] = '{32'h0000_0001, 32'h0001_0101, 32'h0001_0000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic acc, input logic [31:0] a,
                       input logic [31:0] b);
    bus.in_valid_i = 1'b1;
    bus.in_op_i    = op;
    bus.in_acc_i   = acc;
    bus.in_a_i     = a;
    bus.in_b_i     = b;
  endtask

  task automatic idle();
    bus.in_valid_i = 1'b0;
    bus.in_acc_i   = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.in_op_i     = '0;
    bus.in_a_i      = '0;
    bus.in_b_i      = '0;
    bus.out_ready_i = 1'b1;
    idle();
    step();
    step();
    check("rst_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_result", bus.out_result_o, 32'd0);
    check("rst_err", 32'(bus.out_err_o), 32'd0);
    rst = 1'b0;
    step();
    check("rst_ready", 32'(bus.in_ready_o), 32'd1);

    // Basic ops back to back, a=5 b=3.
    for (int i = 0; i < 6; i++) begin
      drive(4'(i), 1'b0, 32'd5, 32'd3);
      step();
      if (i == 0) begin
        check("lat_valid", 32'(bus.out_valid_o), 32'd0);
      end else begin
        check("basic_valid", 32'(bus.out_valid_o), 32'd1);
        check("basic_result", bus.out_result_o, exp_basic[i-1]);
      end
    end
    idle();
    step();
    check("basic_valid", 32'(bus.out_valid_o), 32'd1);
    check("basic_result", bus.out_result_o, exp_basic[5]);
    step();
    check("drain_valid", 32'(bus.out_valid_o), 32'd0);

    // Lane reductions; b is ignored.
    for (int i = 0; i < 3; i++) begin
      drive(red_ops[i], 1'b0, 32'h00FF_0F01, 32'hFFFF_FFFF);
      step();
      if (i > 0) check("red_result", bus.out_result_o, exp_red[i-1]);
    end
    idle();
    step();
    check("red_result", bus.out_result_o, exp_red[2]);

    // Accumulate chain; operand A of acc ops is garbage and must be ignored.
    drive(4'd2, 1'b0, 32'd5, 32'd0);
    step();
    drive(4'd2, 1'b1, 32'hDEAD_BEEF, 32'd3);
    step();
    check("acc_xor0", bus.out_result_o, 32'd5);
    drive(4'd0, 1'b1, 32'h1234_5678, 32'hE);
    step();
    check("acc_xor1", bus.out_result_o, 32'd6);
    idle();
    step();
    check("acc_and", bus.out_result_o, 32'd6);

    // Illegal op leaves accumulator at 6.
    drive(4'hF, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    drive(4'd1, 1'b1, 32'd0, 32'd1);
    step();
    check("ill_err", 32'(bus.out_err_o), 32'd1);
    check("ill_result", bus.out_result_o, 32'd0);
    idle();
    step();
    check("ill_next_err", 32'(bus.out_err_o), 32'd0);
    check("ill_next_result", bus.out_result_o, 32'd7);
    step();

    // Backpressure: two ops fill the pipe, the third waits.
    bus.out_ready_i = 1'b0;
    drive(4'd1, 1'b0, 32'h1, 32'h2);
    #1;
    check("bp_ready0", 32'(bus.in_ready_o), 32'd1);
    step();
    drive(4'd0, 1'b0, 32'hF, 32'h6);
    check("bp_ready1", 32'(bus.in_ready_o), 32'd1);
    step();
    check("bp_ready_full", 32'(bus.in_ready_o), 32'd0);
    check("bp_valid", 32'(bus.out_valid_o), 32'd1);
    check("bp_result", bus.out_result_o, 32'h3);
    drive(4'd2, 1'b0, 32'hF0, 32'hFF);
    step();
    check("bp_ready_hold", 32'(bus.in_ready_o), 32'd0);
    check("bp_stable0", bus.out_result_o, 32'h3);
    step();
    check("bp_stable1", bus.out_result_o, 32'h3);
    bus.out_ready_i = 1'b1;
    #1;
    check("bp_ready_release", 32'(bus.in_ready_o), 32'd1);
    step();
    check("bp_order1", bus.out_result_o, 32'h6);
    idle();
    step();
    check("bp_order2", bus.out_result_o, 32'h0F);
    step();
    check("bp_drain", 32'(bus.out_valid_o), 32'd0);

    // Reset with two ops in flight clears the pipe and the accumulator.
    drive(4'd1, 1'b0, 32'h1, 32'h0);
    step();
    drive(4'd1, 1'b0, 32'h2, 32'h0);
    step();
    rst = 1'b1;
    idle();
    step();
    check("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
    check("mid_rst_result", bus.out_result_o, 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready_o), 32'd1);
    rst = 1'b0;
    drive(4'd1, 1'b1, 32'hFFFF_FFFF, 32'd0);
    step();
    idle();
    step();
    check("post_rst_valid", 32'(bus.out_valid_o), 32'd1);
    check("post_rst_acc", bus.out_result_o, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pulp_logic_pipe.md
# pulp_logic_pipe

Parametrised, pipelined bitwise logic unit with valid/ready handshakes, per-lane SIMD reductions and an accumulate mode that chains each result into the next operation. It supersedes the single-cycle AND/OR/XOR path as a standalone execution-side unit, sitting between an issue stage (upstream handshake) and a writeback/consumer stage (downstream handshake). Throughput is one operation per cycle; latency is two cycles.

## Interface
- WIDTH, 32, datapath width in bits.
- LANE_W, 8, SIMD lane width for reductions; WIDTH % LANE_W == 0 (elaboration-time assertion).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid_i  input  1  upstream operation valid.
- in_ready_o  output  1  unit can accept an operation this cycle.
- in_op_i  input  4  operation code, logic_op_e.
- in_acc_i  input  1  1 = replace operand A with the accumulator.
- in_a_i  input  WIDTH  operand A.
- in_b_i  input  WIDTH  operand B.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  downstream accepts the result.
- out_result_o  output  WIDTH  result.
- out_err_o  output  1  result came from an illegal opcode.

## Operation
- Opcodes: 0 AND a&b; 1 OR a|b; 2 XOR a^b; 3 ANDN a&~b; 4 ORN a|~b; 5 XNOR ~(a^b); 6 RAND; 7 ROR; 8 RXOR; 9–15 illegal.
- Reductions (6–8):
  - Applied per LANE_W lane of a.
  - The lane result goes in bit 0 of that lane; the other bits of the lane are 0.
  - b is ignored.
- Illegal opcode: result 0, err 1, accumulator unchanged.
- Stage 1 (S1) registers op, acc flag, a, b and the valid bit.
- Stage 2 (S2):
  - Computes the operation on the S1 contents.
  - Effective A is the accumulator when the acc flag is set, otherwise a.
  - Registers the result, err and valid bit.
- Accumulator (WIDTH bits):
  - Loaded with the S2 result on every S2 load of a legal op.
  - Back-to-back acc operations chain with no bubble and no forwarding: the op evaluates at the same edge the accumulator updates.
- Handshake, per stage:
  - s2_move = !s2_valid | out_ready_i.
  - s1_move = !s1_valid | s2_move.
  - in_ready_o = s1_move. This is a combinational path from out_ready_i, which is intended.
- Transfers and holds:
  - An input transfer occurs when in_valid_i & in_ready_o.
  - Stage contents hold while the stage is stalled.
  - out_* stay stable while out_valid_o & !out_ready_i.
- in_op_i/in_a_i/in_b_i are don't-care when in_valid_i=0.

## Timing
- Reset values: out_valid_o 0, out_result_o 0, out_err_o 0, accumulator 0, S1 valid 0.
- in_ready_o is 1 in the first cycle after reset deasserts.
- Latency: input accepted at edge N gives out_valid_o high after edge N+1, when the downstream is not stalled.
- Throughput: one op per cycle with out_ready_i held high.
- Full stall with out_ready_i=0:
  - S2 holds one op and S1 holds one op.
  - in_ready_o drops once both are valid.
  - At most 2 ops are in flight.
- out_ready_i rising while full: the S2 op completes, S1 moves to S2, and a new input is accepted in the same cycle.
- rst asserted mid-operation: all in-flight ops are discarded and the accumulator clears at that edge. No partial output.
- An acc op with an empty history uses accumulator 0.

## Structure
- Package pulp_logic_pkg:
  - logic_op_e enum (4-bit, values above).
  - LOGIC_OP_LAST constant for the legality check.
- Sub-module pulp_logic_lane:
  - Combinational, LANE_W wide.
  - Computes all ops for one lane, including its reduction bit.
  - Instantiated WIDTH/LANE_W times by generate in S2.
- Top level holds only the handshake, stage registers, accumulator and err logic.

## Test plan
- Basic ops, WIDTH=32, out_ready_i=1:
  - a=5, b=3 with AND/OR/XOR/ANDN/ORN/XNOR, issued back to back.
  - Results are 1, 7, 6, 0x4, 0xFFFFFFFD, 0xFFFFFFF9 on consecutive cycles, each 2 cycles after its input.
- Reductions, LANE_W=8, a=0x00FF0F01:
  - RXOR gives 0x00000001.
  - ROR gives 0x00010101.
  - RAND gives 0x00010000.
- Accumulate chain:
  - XOR a=5 b=0, then acc XOR b=3, then acc AND b=0xE.
  - Results are 5, 6, 6, and the accumulator reads 6.
- Backpressure:
  - Hold out_ready_i=0 and issue 3 ops.
  - in_ready_o falls after 2 accepts; out_result_o stays stable.
  - Release out_ready_i: all 3 results arrive in order, one per cycle.
- Illegal op 0xF, with accumulator = 6:
  - out_err_o=1 and out_result_o=0.
  - A following acc OR b=1 gives 7.
- Reset mid-stream with 2 ops in flight:
  - Next cycle: out_valid_o=0, in_ready_o=1.
  - A following acc OR b=0 gives 0.
